// File: rtl/icache_fetcher.sv
// Instruction-fetch front end: direct-mapped one-word-per-line I-cache that
// fills a missing line from a byte-wide memory port, four bytes little-endian.
module icache_fetcher #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        busy,
  output logic        instruction_ready,
  output logic [31:0] instruction_addr,
  output logic [31:0] instruction_data,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_reg;
  logic [2:0]            cnt_reg;
  logic [31:0]           pc_reg;
  logic [23:0]           bytes_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           data_reg;
  logic [LINES-1:0]      valid_reg;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [31:0]           req_pc;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [31:0]           fill_word;
  logic                  hit;
  logic                  fill;

  assign req_pc     = fetch_pc & ~32'h3;
  assign req_index  = req_pc[INDEX_BITS+1:2];
  assign req_tag    = req_pc[31:INDEX_BITS+2];
  assign fill_index = pc_reg[INDEX_BITS+1:2];
  assign fill_word  = {mem_din, bytes_reg};
  // Lookup is combinational so a hit can respond in the very next cycle.
  assign hit        = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
  assign fill       = !rst && !flush && (state_reg == S_MISS) && (cnt_reg == 3'd4);

  assign busy              = (state_reg != S_IDLE);
  assign instruction_ready = (state_reg == S_RESP);
  assign instruction_addr  = addr_reg;
  assign instruction_data  = data_reg;
  assign mem_req           = (state_reg == S_MISS) && (cnt_reg < 3'd4);
  assign mem_a             = mem_req ? (pc_reg + 32'(cnt_reg)) : 32'h0;

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill && (fill_index == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_index]  <= pc_reg[31:INDEX_BITS+2];
      data_mem[fill_index] <= fill_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
      pc_reg    <= 32'h0;
      bytes_reg <= 24'h0;
      addr_reg  <= 32'h0;
      data_reg  <= 32'h0;
    end else if (flush) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (fetch_valid) begin
            pc_reg <= req_pc;
            if (hit) begin
              state_reg <= S_RESP;
              addr_reg  <= req_pc;
              data_reg  <= data_mem[req_index];
            end else begin
              state_reg <= S_MISS;
              cnt_reg   <= 3'd0;
            end
          end
        end
        S_MISS: begin
          cnt_reg <= cnt_reg + 3'd1;
          // Byte k arrives one cycle after its address, i.e. while cnt == k+1.
          case (cnt_reg)
            3'd1:    bytes_reg[7:0]   <= mem_din;
            3'd2:    bytes_reg[15:8]  <= mem_din;
            3'd3:    bytes_reg[23:16] <= mem_din;
            default: ;
          endcase
          if (cnt_reg == 3'd4) begin
            state_reg <= S_RESP;
            addr_reg  <= pc_reg;
            data_reg  <= fill_word;
          end
        end
        S_RESP:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
